and_serial_8bit: RTL



---
 rtl/and_serial_8bit.sv | 112 +++++++++++
 1 files changed

// File: rtl/and_serial_8bit.sv
// Bit-serial bitwise AND of two WIDTH-bit operands.
// Operands arrive over a valid/ready handshake. One result bit is formed per
// clock through a single AND gate instance, LSB first. The assembled result
// is then presented over an output valid/ready handshake.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous, active-high reset
//   inA/inB  operands, sampled only on the accepting edge
//   inValid  operands valid
//   inReady  block can accept operands (high only in idle)
//   outY     result register (meaningful only while outValid is high)
//   outValid result valid, held until outReady is seen
//   outReady downstream accepts result
//   busy     high while shifting or holding a result
module and_serial_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] outY,
  output logic             outValid,
  input  logic             outReady,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sha_q;
  logic [WIDTH-1:0] shb_q;
  logic [WIDTH-1:0] res_q;
  logic [CntW-1:0]  cnt_q;
  logic             ready_q;
  logic             valid_q;
  logic             busy_q;
  logic             and_bit;

  // The one and only AND gate in the datapath.
  and and_gate (and_bit, sha_q[0], shb_q[0]);

  // Handshake outputs are registered and tracked alongside the state, so no
  // combinational path exists from inValid/outReady to inReady/outValid.
  // ready_q stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (inValid && ready_q) begin
            sha_q   <= inA;
            shb_q   <= inB;
            res_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          // Zeros shift in at the top so operand registers never see new input data.
          res_q <= {and_bit, res_q[WIDTH-1:1]};
          sha_q <= sha_q >> 1;
          shb_q <= shb_q >> 1;
          if (cnt_q == LastCnt) begin
            // Counter holds here; it only restarts on the next accept.
            valid_q <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (outReady) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          ready_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign inReady  = ready_q;
  assign outValid = valid_q;
  assign busy     = busy_q;
  assign outY     = res_q;

endmodule
